// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and types for the systolic array result path
package tpu_pkg;

    localparam int N      = 32;
    localparam int DATA_W = 32;
    localparam int ROW_W  = 8;

    typedef logic [DATA_W-1:0] psum_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } deskew_state_e;

endpackage

// File: rtl/systolic_result_deskew_if.sv
// rtl/systolic_result_deskew_if.sv - tile control and row stream bundle for the deskew block
interface systolic_result_deskew_if;
    import tpu_pkg::*;

    logic                start_i;
    logic [ROW_W-1:0]    num_rows_i;
    logic                valid_i;
    psum_t [N-1:0]       data_i;
    logic                valid_o;
    psum_t [N-1:0]       data_o;
    logic [ROW_W-1:0]    row_idx_o;
    logic                done_o;
    logic                busy_o;
    logic                err_o;

    modport master (
        output start_i, num_rows_i, valid_i, data_i,
        input  valid_o, data_o, row_idx_o, done_o, busy_o, err_o
    );

    modport slave (
        input  start_i, num_rows_i, valid_i, data_i,
        output valid_o, data_o, row_idx_o, done_o, busy_o, err_o
    );

endinterface

// File: rtl/deskew_delay_line.sv
// rtl/deskew_delay_line.sv - fixed-depth free-running shift register for one array column
module deskew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] stage_q [DEPTH];

    // shift every cycle; the array never stalls so neither does the delay
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_result_deskew.sv
// rtl/systolic_result_deskew.sv - realigns skewed array columns into whole rows and tracks tile progress
module systolic_result_deskew
    import tpu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    systolic_result_deskew_if.slave bus
);

    deskew_state_e     state_q, state_d;
    logic [ROW_W-1:0]  num_rows_q;
    logic [ROW_W-1:0]  in_cnt_q;
    logic [ROW_W-1:0]  out_cnt_q;
    logic [N-1:0]      valid_pipe_q;
    logic              done_q, done_d;
    logic              err_q;
    logic              accept;
    logic              start_tile;
    logic              in_last;
    logic              out_last;
    logic              out_valid;
    logic              err_set;
    psum_t [N-1:0]     aligned;

    // column j already lags column 0 by j cycles, so it needs N-j more stages
    for (genvar j = 0; j < N; j++) begin : g_col
        deskew_delay_line #(
            .DEPTH  (N - j),
            .DATA_W (DATA_W)
        ) u_delay (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .data_i (bus.data_i[j]),
            .data_o (aligned[j])
        );
    end

    assign out_valid = valid_pipe_q[N-1];
    assign in_last   = (in_cnt_q + ROW_W'(1)) == num_rows_q;
    assign out_last  = out_valid && ((out_cnt_q + ROW_W'(1)) == num_rows_q);
    assign err_set   = bus.valid_i && (state_q != RUN);

    // next-state decode: accept rows in RUN, wait for the last aligned row in DRAIN
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        start_tile = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    start_tile = 1'b1;
                    if (bus.num_rows_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.valid_i) begin
                    accept = 1'b1;
                    if (in_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // tile bookkeeping: row counts, completion pulse, sticky protocol error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num_rows_q <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= done_d;
            if (start_tile) begin
                num_rows_q <= bus.num_rows_i;
                in_cnt_q   <= '0;
                out_cnt_q  <= '0;
            end else begin
                if (accept) begin
                    in_cnt_q <= in_cnt_q + ROW_W'(1);
                end
                if (out_valid) begin
                    out_cnt_q <= out_cnt_q + ROW_W'(1);
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (start_tile) begin
                err_q <= 1'b0;
            end
        end
    end

    // row-valid marker travels alongside column 0; dropped rows enter as 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_pipe_q <= '0;
        end else begin
            valid_pipe_q <= {valid_pipe_q[N-2:0], accept};
        end
    end

    assign bus.valid_o   = out_valid;
    assign bus.data_o    = aligned;
    assign bus.row_idx_o = out_cnt_q;
    assign bus.done_o    = done_q;
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_systolic_result_deskew.sv
// tb/tb_systolic_result_deskew.sv - randomized self-checking bench for systolic_result_deskew
module tb_systolic_result_deskew;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_result_deskew_if bus ();

    systolic_result_deskew dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int due;
        int src;
        int idx;
    } row_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    bit            checking = 1'b0;

    row_t          pend [$];
    psum_t [N-1:0] hist [int];

    bit            m_busy, m_err, m_done_next;
    int            m_total, m_acc, m_emit;

    bit            exp_valid, exp_done, exp_busy, exp_err, exp_zero;
    int            exp_src, exp_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_cycle();
        bit was_busy;
        was_busy = m_busy;
        if (rst) begin
            pend.delete();
            m_busy      = 1'b0;
            m_err       = 1'b0;
            m_done_next = 1'b0;
            m_total     = 0;
            m_acc       = 0;
            m_emit      = 0;
            checking    = 1'b1;
            exp_zero    = 1'b1;
        end else begin
            exp_zero    = 1'b0;
            m_done_next = 1'b0;
            if (!was_busy) begin
                if (bus.start_i) begin
                    m_err = 1'b0;
                    if (bus.num_rows_i == 0) begin
                        m_done_next = 1'b1;
                    end else begin
                        m_busy  = 1'b1;
                        m_total = int'(bus.num_rows_i);
                        m_acc   = 0;
                        m_emit  = 0;
                    end
                end
                if (bus.valid_i) m_err = 1'b1;
            end else if (m_acc < m_total) begin
                if (bus.valid_i) begin
                    pend.push_back('{due: cyc + N, src: cyc, idx: m_acc});
                    m_acc++;
                end
            end else if (bus.valid_i) begin
                m_err = 1'b1;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                void'(pend.pop_front());
                m_emit++;
                if (m_emit == m_total) begin
                    m_busy      = 1'b0;
                    m_done_next = 1'b1;
                end
            end
        end
        exp_valid = (pend.size() > 0) && (pend[0].due == cyc + 1);
        if (exp_valid) begin
            exp_src = pend[0].src;
            exp_idx = pend[0].idx;
        end
        exp_done = m_done_next;
        exp_busy = m_busy;
        exp_err  = m_err;
    endtask

    task automatic step();
        @(negedge clk);
        if (checking) begin
            check("valid_o", 32'(bus.valid_o), 32'(exp_valid));
            check("done_o",  32'(bus.done_o),  32'(exp_done));
            check("busy_o",  32'(bus.busy_o),  32'(exp_busy));
            check("err_o",   32'(bus.err_o),   32'(exp_err));
            if (exp_valid) begin
                check("row_idx_o", 32'(bus.row_idx_o), 32'(exp_idx));
                for (int j = 0; j < N; j++) begin
                    check($sformatf("data_o[%0d]", j), bus.data_o[j], hist[exp_src + j][j]);
                end
            end
            if (exp_zero) begin
                check("reset_row_idx_o", 32'(bus.row_idx_o), 32'd0);
                for (int j = 0; j < N; j++) begin
                    check($sformatf("reset_data_o[%0d]", j), bus.data_o[j], 32'd0);
                end
            end
        end
        hist[cyc] = bus.data_i;
        model_cycle();
        cyc++;
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            bus.data_i[j] = $urandom();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic start_tile(input int rows);
        bus.start_i    = 1'b1;
        bus.num_rows_i = ROW_W'(rows);
        step();
        bus.start_i    = 1'b0;
        bus.num_rows_i = ROW_W'($urandom());
    endtask

    task automatic send_row(input int gap);
        bus.valid_i = 1'b1;
        step();
        bus.valid_i = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((m_busy || pend.size() > 0 || m_done_next) && k < 200) begin
            step();
            k++;
        end
        check("drain_timeout", 32'(k < 200), 32'd1);
    endtask

    task automatic wait_done_cycle();
        int k;
        k = 0;
        while (!m_done_next && k < 200) begin
            step();
            k++;
        end
        check("done_timeout", 32'(k < 200), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.num_rows_i = '0;
        bus.valid_i    = 1'b0;
        for (int j = 0; j < N; j++) bus.data_i[j] = $urandom();

        idle(3);
        rst = 1'b0;

        start_tile(4);
        repeat (4) send_row(0);
        wait_idle();

        start_tile(3);
        send_row(4);
        send_row(4);
        send_row(0);
        wait_idle();

        start_tile(0);
        idle(3);

        start_tile(2);
        send_row(2);
        send_row(1);
        send_row(0);
        wait_idle();
        send_row(2);
        idle(2);
        start_tile(1);
        send_row(0);
        wait_idle();

        start_tile(6);
        repeat (4) send_row(1);
        idle(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(40);
        start_tile(2);
        send_row(0);
        send_row(3);
        wait_idle();

        start_tile(2);
        send_row(0);
        send_row(0);
        wait_done_cycle();
        start_tile(1);
        send_row(0);
        wait_idle();

        repeat (6) begin
            int rows;
            rows = $urandom_range(1, 6);
            start_tile(rows);
            repeat (rows) send_row($urandom_range(0, 3));
            wait_idle();
            idle($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
